// File: rtl/seg_ctrl_pkg.sv
// Shared constants, FSM encoding and BCD helper for the seven-segment display controller.
package seg_ctrl_pkg;

    localparam int         W         = 14;
    localparam int         NDIG      = 4;
    localparam logic [3:0] DASH      = 4'd10;
    localparam logic [W-1:0] BCD_MAX = 14'd9999;
    localparam logic [3:0] ITER_LAST = 4'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    // Double-dabble correction: any nibble of 5 or more gets +3 before the next shift.
    function automatic logic [4*NDIG-1:0] bcd_adjust(input logic [4*NDIG-1:0] bcd);
        logic [4*NDIG-1:0] res;
        res = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_bin2bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per clock).
// Digits only reach the bcd output register in DONE, together with the valid pulse.
module bin2bcd_seq
    import seg_ctrl_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  bin,
    output logic [15:0]   bcd,
    output logic          valid,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [15:0]   bcd_sr_q, bcd_sr_d;
    logic [W-1:0]  bin_sr_q, bin_sr_d;
    logic [3:0]    iter_q, iter_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          valid_q, valid_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            bcd_sr_q <= '0;
            bin_sr_q <= '0;
            iter_q   <= '0;
            bcd_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_sr_q <= bcd_sr_d;
            bin_sr_q <= bin_sr_d;
            iter_q   <= iter_d;
            bcd_q    <= bcd_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bcd_sr_d = bcd_sr_q;
        bin_sr_d = bin_sr_q;
        iter_d   = iter_q;
        bcd_d    = bcd_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sr_d = bin;
                    bcd_sr_d = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                // Out-of-range values skip the shifting entirely and show dashes.
                if (bin_sr_q > BCD_MAX) begin
                    bcd_sr_d = {NDIG{DASH}};
                    state_d  = DONE;
                end else begin
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_sr_d, bin_sr_d} = {bcd_adjust(bcd_sr_q), bin_sr_q} << 1;
                iter_d = iter_q + 4'd1;
                if (iter_q == ITER_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = bcd_sr_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bcd   = bcd_q;
    assign valid = valid_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: rtl/seg_display_ctrl.sv
// Shares a 4-digit seven-segment display between two binary sources, rotating every DWELL clocks
// and re-converting the shown value whenever it or the active source changes.
module seg_display_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter int DWELL = 50000000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  val0,
    input  logic          upd0,
    input  logic [W-1:0]  val1,
    input  logic          upd1,
    input  logic          freeze,
    output logic [3:0]    dig0,
    output logic [3:0]    dig1,
    output logic [3:0]    dig2,
    output logic [3:0]    dig3,
    output logic          src,
    output logic          busy,
    output logic          done
);

    localparam int            DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    logic [W-1:0]  val0_q, val0_d;
    logic [W-1:0]  val1_q, val1_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic          src_q, src_d;
    logic          pending_q, pending_d;

    logic          rotate;
    logic          conv_start;
    logic          conv_busy;
    logic          conv_valid;
    logic [15:0]   conv_bcd;
    logic [W-1:0]  conv_bin;

    always_ff @(posedge clock) begin
        if (reset) begin
            val0_q      <= '0;
            val1_q      <= '0;
            dwell_cnt_q <= '0;
            src_q       <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            val0_q      <= val0_d;
            val1_q      <= val1_d;
            dwell_cnt_q <= dwell_cnt_d;
            src_q       <= src_d;
            pending_q   <= pending_d;
        end
    end

    always_comb begin
        val0_d      = upd0 ? val0 : val0_q;
        val1_d      = upd1 ? val1 : val1_q;
        rotate      = !freeze && (dwell_cnt_q == DWELL_LAST);
        dwell_cnt_d = dwell_cnt_q;
        if (!freeze) begin
            dwell_cnt_d = rotate ? '0 : dwell_cnt_q + DW'(1);
        end
        src_d      = rotate ? ~src_q : src_q;
        conv_start = pending_q && !conv_busy;
        conv_bin   = src_q ? val1_q : val0_q;
        // A new request on the same edge as a snapshot must survive: the snapshot saw the old value.
        pending_d = pending_q;
        if (conv_start) begin
            pending_d = 1'b0;
        end
        if (rotate || (upd0 && !src_q) || (upd1 && src_q)) begin
            pending_d = 1'b1;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .valid (conv_valid),
        .busy  (conv_busy)
    );

    assign dig0 = conv_bcd[3:0];
    assign dig1 = conv_bcd[7:4];
    assign dig2 = conv_bcd[11:8];
    assign dig3 = conv_bcd[15:12];
    assign src  = src_q;
    assign busy = conv_busy;
    assign done = conv_valid;

endmodule
